// File: rtl/posit_pack_if.sv
// rtl/posit_pack_if.sv - operand/result handshake bundle for the posit encoder
interface posit_pack_if #(
    parameter int N  = 32,
    parameter int es = 2
);
    localparam int SW = $clog2(N) + es + 2;

    logic                 in_valid;
    logic                 in_ready;
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [SW-1:0] scale;
    logic [N-1:0]         frac;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out;

    modport master (
        output in_valid, sign, zero, nar, scale, frac, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, sign, zero, nar, scale, frac, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/posit_pack.sv
// rtl/posit_pack.sv - 3-stage posit encoder; define POSIT_PACK_RNE_EN for round-to-nearest-even, else truncate
module posit_pack #(
    parameter int N  = 32,
    parameter int es = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    posit_pack_if.slave   pif
);
    localparam int SW = $clog2(N) + es + 2;
    localparam int VW = 2 * N + es + 2;
    localparam logic signed [SW-1:0] KMAX = SW'(N - 2);
    localparam logic signed [SW-1:0] KMIN = SW'(-(N - 1));

`ifdef POSIT_PACK_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    logic adv;
    assign adv          = !pif.out_valid || pif.out_ready;
    assign pif.in_ready = adv;

    // S1: split scale into regime run length and exponent bits
    logic signed [SW-1:0] k;
    assign k = $signed(pif.scale) >>> es;

    logic              s1_valid, s1_nar, s1_zero, s1_sign;
    logic              s1_max, s1_min, s1_neg;
    logic [SW-1:0]     s1_sh;
    logic [es+N-1:0]   s1_tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_nar   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_max   <= 1'b0;
            s1_min   <= 1'b0;
            s1_neg   <= 1'b0;
            s1_sh    <= '0;
            s1_tail  <= '0;
        end else if (adv) begin
            s1_valid <= pif.in_valid;
            s1_nar   <= pif.nar;
            s1_zero  <= pif.zero;
            s1_sign  <= pif.sign;
            s1_max   <= (k >= KMAX);
            s1_min   <= (k <= KMIN);
            s1_neg   <= k[SW-1];
            s1_sh    <= k[SW-1] ? ~k : k;
            s1_tail  <= {pif.scale[es-1:0], pif.frac};
        end
    end

    // S2: a {1,0} (or {0,1}) seed shifted arithmetically grows the regime run
    logic signed [VW-1:0] v;
    logic [N-2:0]         body;
    logic                 guard, sticky, inc;
    logic [N-1:0]         sum, pos_d;

    assign v      = $signed({~s1_neg, s1_neg, s1_tail, {N{1'b0}}}) >>> s1_sh;
    assign body   = v[VW-1 -: N-1];
    assign guard  = v[VW-N];
    assign sticky = |v[VW-N-1:0];
    assign inc    = RNE_EN && guard && (sticky || body[0]);
    assign sum    = {1'b0, body} + {{(N-1){1'b0}}, inc};

    always_comb begin
        pos_d = sum;
        if (sum[N-1])
            pos_d = {1'b0, {(N-1){1'b1}}};
        if (sum == '0)
            pos_d = {{(N-1){1'b0}}, 1'b1};
        if (s1_max)
            pos_d = {1'b0, {(N-1){1'b1}}};
        else if (s1_min)
            pos_d = {{(N-1){1'b0}}, 1'b1};
    end

    logic         s2_valid, s2_nar, s2_zero, s2_sign;
    logic [N-1:0] s2_pos;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_nar   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_sign  <= 1'b0;
            s2_pos   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_nar   <= s1_nar;
            s2_zero  <= s1_zero;
            s2_sign  <= s1_sign;
            s2_pos   <= pos_d;
        end
    end

    // S3: specials override the magnitude, negatives are two's complemented
    logic [N-1:0] out_d, out_q;
    logic         out_valid_q;

    always_comb begin
        out_d = s2_sign ? (~s2_pos + {{(N-1){1'b0}}, 1'b1}) : s2_pos;
        if (s2_zero)
            out_d = '0;
        if (s2_nar)
            out_d = {1'b1, {(N-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid;
            out_q       <= out_d;
        end
    end

    assign pif.out_valid = out_valid_q;
    assign pif.out       = out_q;
endmodule
